// File: rtl/ac_uart_rx_stream.sv
// Oversampling UART receiver: 3-sample majority voting, parity/stop checking and a
// show-ahead receive FIFO whose head word is presented on an AXI4-Stream master.
module ac_uart_rx_stream #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic                             rx_i,
    input  logic                             enable_i,
    input  logic [DIV_WIDTH-1:0]             baud_div_i,
    input  logic [1:0]                       parity_mode_i,
    input  logic                             stop2_i,
    input  logic                             clear_i,
    output logic [DATA_BITS-1:0]             m_axis_tdata,
    output logic [1:0]                       m_axis_tuser,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
    output logic                             overrun_o,
    output logic                             busy_o
);
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int S_W    = $clog2(OVERSAMPLE);
    localparam int BC_W   = $clog2(DATA_BITS + 1);
    localparam int WORD_W = DATA_BITS + 2;

    localparam logic [S_W-1:0]   S_A    = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_B    = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0]   S_C    = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0]   S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0]  BITS   = BC_W'(DATA_BITS);
    localparam logic [LVL_W-1:0] FULL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    // ---------------- input synchroniser ----------------
    logic sync1, rxs;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_i;
            rxs   <= sync1;
        end
    end

    // ---------------- oversample tick generator ----------------
    logic [DIV_WIDTH-1:0] div_cnt, div_lat;
    logic                 tick, restart;

    assign tick = enable_i && (div_cnt == div_lat);

    // The divisor is latched only at a wrap so a mid-period change never truncates a tick.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            div_cnt <= '0;
            div_lat <= '0;
        end else if (!enable_i || restart || tick) begin
            div_cnt <= '0;
            div_lat <= baud_div_i;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    // ---------------- frame FSM ----------------
    state_t               state, state_n;
    logic [S_W-1:0]       s_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 samp_a, samp_b, perr, ferr;
    logic                 vote_ev, wrap, vote, push;
    logic                 parity_en, parity_odd;
    logic                 push_q;
    logic [WORD_W-1:0]    push_word;

    assign parity_en  = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
    assign parity_odd = (parity_mode_i == 2'b10);
    assign vote_ev    = tick && (s_cnt == S_C);
    assign wrap       = tick && (s_cnt == S_LAST);
    assign vote       = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_n;
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_n = state;
        restart = 1'b0;
        push    = 1'b0;
        if (!enable_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (!rxs) begin
                    state_n = START;
                    restart = 1'b1;
                end
                START:  if (vote_ev && vote) state_n = IDLE;
                        else if (wrap)       state_n = DATA;
                DATA:   if (wrap && bit_cnt == BITS) state_n = parity_en ? PARITY : STOP1;
                PARITY: if (wrap) state_n = STOP1;
                STOP1:  if (vote_ev) begin
                    if (stop2_i) begin
                        state_n = STOP2;
                    end else begin
                        state_n = IDLE;
                        push    = 1'b1;
                    end
                end
                STOP2:  if (vote_ev) begin
                    state_n = IDLE;
                    push    = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_cnt     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            push_q    <= 1'b0;
            push_word <= '0;
        end else begin
            push_q <= push;
            if (push) push_word <= {ferr | ~vote, perr, shreg};

            if (state == IDLE)  s_cnt <= '0;
            else if (tick)      s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + S_W'(1);

            if (restart) begin
                bit_cnt <= '0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
            end

            if (tick && s_cnt == S_A) samp_a <= rxs;
            if (tick && s_cnt == S_B) samp_b <= rxs;

            if (vote_ev) begin
                if (state == DATA) begin
                    shreg   <= {vote, shreg[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + BC_W'(1);
                end else if (state == PARITY) begin
                    perr <= vote ^ (^shreg) ^ parity_odd;
                end else if ((state == STOP1 || state == STOP2) && !vote) begin
                    ferr <= 1'b1;
                end
            end
        end
    end

    assign busy_o = (state != IDLE);

    // ---------------- receive FIFO ----------------
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [WORD_W-1:0] head;
    logic              full, pop, wr_en;

    assign full  = (level == FULL);
    assign pop   = m_axis_tvalid && m_axis_tready;
    assign wr_en = push_q && !clear_i && (!full || pop);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overrun_o <= 1'b0;
        end else if (clear_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop)      level <= level + LVL_W'(1);
            else if (pop && !wr_en) level <= level - LVL_W'(1);
            if (push_q && !wr_en) overrun_o <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; its contents only matter once level
    // says an entry is valid, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge ACLK) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    // Outputs are gated by tvalid so stale storage never leaks out while empty.
    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = (level != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head[DATA_BITS-1:0] : '0;
    assign m_axis_tuser  = m_axis_tvalid ? head[WORD_W-1:DATA_BITS] : '0;
    assign fifo_level_o  = level;

endmodule

// File: tb/tb_ac_uart_rx_stream.sv
// Self-checking bench for ac_uart_rx_stream: table-driven frames, hand-written
// disruption sequences and randomized frames checked against a frame-level model.
module tb_ac_uart_rx_stream;
    logic       ACLK;
    logic       ARESETN;
    logic       rx_i;
    logic       enable_i;
    logic [15:0] baud_div_i;
    logic [1:0] parity_mode_i;
    logic       stop2_i;
    logic       clear_i;
    logic [7:0] m_axis_tdata;
    logic [1:0] m_axis_tuser;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [4:0] fifo_level_o;
    logic       overrun_o;
    logic       busy_o;

    ac_uart_rx_stream #(
        .DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(16), .DIV_WIDTH(16)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .rx_i(rx_i), .enable_i(enable_i),
        .baud_div_i(baud_div_i), .parity_mode_i(parity_mode_i), .stop2_i(stop2_i),
        .clear_i(clear_i), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .fifo_level_o(fifo_level_o), .overrun_o(overrun_o), .busy_o(busy_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] user;
    } word_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       st2;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic [1:0] exp_user;
    } vec_t;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    beats    = 0;
    int    bit_cyc  = 32;
    word_t mdl_q[$];
    logic  mdl_ovr  = 1'b0;
    word_t mon_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    // Frame-level reference: error tags straight from the bits put on the wire.
    function automatic logic [1:0] model_user(input logic [7:0] d, input logic [1:0] pm,
                                              input logic st2, input logic pbit,
                                              input logic s1, input logic s2);
        logic perr, ferr;
        perr = (pm == 2'b01 && pbit != ^d) || (pm == 2'b10 && pbit != ~^d);
        ferr = !s1 || (st2 && !s2);
        return {ferr, perr};
    endfunction

    function automatic void exp_push(input logic [7:0] d, input logic [1:0] u);
        word_t w;
        w.data = d;
        w.user = u;
        if (m_axis_tready || mdl_q.size() < 16) mdl_q.push_back(w);
        else mdl_ovr = 1'b1;
    endfunction

    task automatic send_bits(input logic [7:0] d, input int n);
        rx_i = 1'b0;
        tick_n(bit_cyc);
        for (int i = 0; i < n; i++) begin
            rx_i = d[i];
            tick_n(bit_cyc);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic st2,
                              input logic pbit, input logic s1, input logic s2);
        parity_mode_i = pm;
        stop2_i       = st2;
        send_bits(d, 8);
        if (pm == 2'b01 || pm == 2'b10) begin
            rx_i = pbit;
            tick_n(bit_cyc);
        end
        rx_i = s1;
        tick_n(bit_cyc);
        if (st2) begin
            rx_i = s2;
            tick_n(bit_cyc);
        end
        rx_i = 1'b1;
        tick_n(2 * bit_cyc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tdata"},  m_axis_tdata,  0);
        check({tag, "_tuser"},  m_axis_tuser,  0);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_level"},  fifo_level_o,  0);
        check({tag, "_overrun"}, overrun_o,    0);
        check({tag, "_busy"},   busy_o,        0);
    endtask

    // Consumer-side scoreboard: every accepted beat must match the model's head word.
    always @(negedge ACLK) begin
        if (ARESETN && m_axis_tvalid && m_axis_tready) begin
            beats++;
            check("beat_expected", 32'(mdl_q.size() != 0), 1);
            if (mdl_q.size() != 0) begin
                mon_w = mdl_q.pop_front();
                check("tdata", m_axis_tdata, mon_w.data);
                check("tuser", m_axis_tuser, mon_w.user);
            end
        end
    end

    initial begin
        vec_t        vecs[6];
        int          beats_before;
        logic [7:0]  d;
        logic [1:0]  pm;
        logic        st2, pb, s1, s2;

        vecs[0] = '{8'hA3, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 2'b01};
        vecs[1] = '{8'hA3, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 2'b00};
        vecs[2] = '{8'h3C, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 2'b10};
        vecs[3] = '{8'h81, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 2'b00};
        vecs[4] = '{8'h5A, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 2'b00};
        vecs[5] = '{8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 2'b10};

        ARESETN       = 1'b0;
        rx_i          = 1'b1;
        enable_i      = 1'b1;
        baud_div_i    = 16'd53;
        parity_mode_i = 2'b00;
        stop2_i       = 1'b0;
        clear_i       = 1'b0;
        m_axis_tready = 1'b1;

        tick_n(3);
        check_all_zero("rst");
        ARESETN = 1'b1;
        tick_n(5);
        check_all_zero("post_rst");

        // 8N1 at the slow divisor: exactly one clean beat
        bit_cyc      = (53 + 1) * 16;
        beats_before = beats;
        exp_push(8'h55, 2'b00);
        send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t1_beats", beats - beats_before, 1);
        check("t1_busy", busy_o, 0);
        check("t1_tvalid", m_axis_tvalid, 0);

        baud_div_i = 16'd1;
        bit_cyc    = (1 + 1) * 16;
        for (int i = 0; i < 6; i++) begin
            exp_push(vecs[i].exp_data, vecs[i].exp_user);
            send_frame(vecs[i].data, vecs[i].pmode, vecs[i].st2,
                       vecs[i].pbit, vecs[i].s1, vecs[i].s2);
            check("tbl_beat_seen", mdl_q.size(), 0);
            check("tbl_level", fifo_level_o, 0);
        end

        // Glitch shorter than the first vote sample
        parity_mode_i = 2'b00;
        stop2_i       = 1'b0;
        rx_i          = 1'b0;
        tick_n(4);
        check("glitch_busy_hi", busy_o, 1);
        tick_n(5 * 2 - 4);
        rx_i = 1'b1;
        tick_n(2 * bit_cyc);
        check("glitch_busy_lo", busy_o, 0);
        check("glitch_level", fifo_level_o, 0);
        check("glitch_tvalid", m_axis_tvalid, 0);

        // Overrun: 17 words into a 16-deep FIFO, drain, then clear
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            exp_push(8'(i), 2'b00);
            send_frame(8'(i), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        check("ovr_level", fifo_level_o, mdl_q.size());
        check("ovr_flag", overrun_o, mdl_ovr);
        check("ovr_head", m_axis_tdata, 8'h00);
        m_axis_tready = 1'b1;
        tick_n(40);
        check("ovr_drained", mdl_q.size(), 0);
        check("ovr_level0", fifo_level_o, 0);
        check("ovr_sticky", overrun_o, 1);
        clear_i = 1'b1;
        tick_n(1);
        clear_i = 1'b0;
        mdl_ovr = 1'b0;
        check("clr_overrun", overrun_o, 0);

        // Clear while words are stored
        m_axis_tready = 1'b0;
        exp_push(8'h21, 2'b00);
        send_frame(8'h21, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_push(8'h42, 2'b00);
        send_frame(8'h42, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_pre_level", fifo_level_o, mdl_q.size());
        clear_i = 1'b1;
        tick_n(1);
        clear_i = 1'b0;
        mdl_q.delete();
        check("clr_level", fifo_level_o, 0);
        check("clr_tvalid", m_axis_tvalid, 0);

        // Asynchronous reset in the middle of a frame
        exp_push(8'h77, 2'b00);
        send_frame(8'h77, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("mrst_pre_tvalid", m_axis_tvalid, 1);
        send_bits(8'hF0, 3);
        check("mrst_pre_busy", busy_o, 1);
        ARESETN = 1'b0;
        #1;
        check_all_zero("mrst");
        mdl_q.delete();
        mdl_ovr = 1'b0;
        rx_i    = 1'b1;
        tick_n(3);
        ARESETN = 1'b1;
        tick_n(bit_cyc);
        m_axis_tready = 1'b1;
        exp_push(8'h12, 2'b00);
        send_frame(8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("mrst_next_seen", mdl_q.size(), 0);

        // Enable dropped in the middle of a frame
        send_bits(8'hF0, 4);
        enable_i = 1'b0;
        tick_n(1);
        check("en_busy", busy_o, 0);
        rx_i = 1'b1;
        tick_n(4);
        enable_i = 1'b1;
        tick_n(2 * bit_cyc);
        check("en_level", fifo_level_o, 0);
        check("en_tvalid", m_axis_tvalid, 0);
        exp_push(8'h12, 2'b00);
        send_frame(8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("en_next_seen", mdl_q.size(), 0);

        // Randomized frames, formats, divisors and consumer stalls
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            pm  = 2'($urandom);
            st2 = 1'($urandom);
            pb  = 1'($urandom);
            s1  = ($urandom % 4) != 0;
            s2  = ($urandom % 4) != 0;
            baud_div_i    = 16'($urandom_range(0, 3));
            bit_cyc       = (int'(baud_div_i) + 1) * 16;
            m_axis_tready = 1'($urandom);
            exp_push(d, model_user(d, pm, st2, pb, s1, s2));
            send_frame(d, pm, st2, pb, s1, s2);
            check("rnd_level", fifo_level_o, mdl_q.size());
        end
        m_axis_tready = 1'b1;
        tick_n(40);
        check("rnd_drained", mdl_q.size(), 0);
        check("rnd_level0", fifo_level_o, 0);
        check("rnd_overrun", overrun_o, mdl_ovr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
